// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci-table arbiter: default widths, burst limit
// and FSM state encoding.
package fib_pkg;
  localparam int FIB_ADDR_W    = 10;
  localparam int FIB_DATA_W    = 16;
  localparam int FIB_MAX_BURST = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fib_ram_arbiter_rr_pick.sv
// Round-robin priority pick: first asserted req at or after ptr, wrapping,
// returned both one-hot and as an index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [PTR_W-1:0] win_idx,
  output logic             any
);
  int idx;
  logic [PTR_W-1:0] pos;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = 0;
    pos     = '0;
    // Scan from the far end back toward ptr so the nearest requester writes last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      pos = PTR_W'(idx);
      if (req[pos]) begin
        win      = '0;
        win[pos] = 1'b1;
        win_idx  = pos;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fib_ram_arbiter.sv
// Round-robin arbiter sharing one Fibonacci table read port among N_REQ requesters;
// a locked winner keeps the port, bounded by MAX_BURST only while others wait.
module fib_ram_arbiter
  import fib_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = FIB_ADDR_W,
  parameter int DATA_W    = FIB_DATA_W,
  parameter int MAX_BURST = FIB_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]       ram_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data
);
  localparam int PTR_W = ptr_width(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [ADDR_W-1:0] addr_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  logic [1:0]        state_reg, state_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [PTR_W-1:0]  owner_reg, owner_next;
  logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic              armed_reg;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [N_REQ-1:0]  rd_valid_reg;
  logic [DATA_W-1:0] rd_data_reg;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0] owner_inc, pick_start, pick_idx;
  logic [N_REQ-1:0] pick_win, owner_mask;
  logic             pick_any, others, hold;

  assign owner_inc  = next_ptr(owner_reg);
  // Leaving a burst restarts the search just past the owner.
  assign pick_start = (state_reg == ST_BURST) ? owner_inc : ptr_reg;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req     (req),
    .ptr     (pick_start),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    owner_mask            = '0;
    owner_mask[owner_reg] = 1'b1;
  end

  assign others = |(req & ~owner_mask);
  // burst_cnt counts owner grants after the entry grant, so CNT_LAST means MAX_BURST given.
  assign hold = (state_reg == ST_BURST) && req[owner_reg] && lock[owner_reg] &&
                !((burst_cnt_reg >= CNT_LAST) && others);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    gnt_next       = '0;
    ram_addr_next  = ram_addr_reg;
    if (armed_reg) begin
      if (hold) begin
        gnt_next[owner_reg] = 1'b1;
        ram_addr_next       = addr_arr[owner_reg];
        burst_cnt_next      = (burst_cnt_reg == CNT_MAX) ? burst_cnt_reg
                                                         : burst_cnt_reg + CNT_W'(1);
      end else begin
        if (state_reg == ST_BURST) begin
          ptr_next       = owner_inc;
          burst_cnt_next = '0;
        end
        if (pick_any) begin
          gnt_next      = pick_win;
          ram_addr_next = addr_arr[pick_idx];
          if (lock[pick_idx]) begin
            state_next     = ST_BURST;
            owner_next     = pick_idx;
            burst_cnt_next = '0;
          end else begin
            state_next = ST_SERVE;
            ptr_next   = next_ptr(pick_idx);
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
    end
  end

  // armed_reg holds off grants for one edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      armed_reg     <= 1'b0;
      gnt_reg       <= '0;
      ram_addr_reg  <= '0;
      rd_valid_reg  <= '0;
      rd_data_reg   <= '0;
    end else begin
      armed_reg     <= 1'b1;
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      gnt_reg       <= gnt_next;
      ram_addr_reg  <= ram_addr_next;
      rd_valid_reg  <= gnt_reg;
      if (|gnt_reg) rd_data_reg <= ram_data;
    end
  end

  assign gnt      = gnt_reg;
  assign ram_addr = ram_addr_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
endmodule

// File: tb/tb_fib_ram_arbiter.sv
// Bench for fib_ram_arbiter: directed vector table, burst/reset/idle sequences,
// and random traffic checked against a behavioural arbitration model.
module tb_fib_ram_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int MB = 8;

  typedef logic [1:0] idx_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lock = '0;
  logic [AW-1:0] a_in [N];
  logic [N*AW-1:0] addr;
  logic [N-1:0]  gnt, rd_valid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, rd_data;
  logic [DW-1:0] fib_table [1024];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign addr[gi*AW +: AW] = a_in[gi];
    end
  endgenerate

  assign ram_data = fib_table[ram_addr];

  always #5 clk = ~clk;

  fib_ram_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .addr     (addr),
    .gnt      (gnt),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: pointer, burst owner and length of the current burst.
  int m_ptr, m_own, m_run;
  bit m_in_burst, m_armed;
  logic [N-1:0]  exp_gnt, exp_rd_valid;
  logic [AW-1:0] exp_ram_addr;
  logic [DW-1:0] exp_rd_data;

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [AW-1:0] ra;
    logic [N-1:0]  rv;
    logic [DW-1:0] rd;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_own = 0; m_run = 0; m_in_burst = 0; m_armed = 0;
    exp_gnt = '0; exp_rd_valid = '0; exp_ram_addr = '0; exp_rd_data = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] g, om;
    int w;
    bit others;
    if (|exp_gnt) exp_rd_data = fib_table[exp_ram_addr];
    exp_rd_valid = exp_gnt;
    g = '0;
    w = -1;
    if (!m_armed) begin
      m_armed = 1;
    end else begin
      om = N'(1) << m_own;
      others = (req & ~om) != '0;
      if (m_in_burst && req[idx_t'(m_own)] && lock[idx_t'(m_own)] && !(m_run >= MB && others)) begin
        w = m_own;
        m_run++;
      end else begin
        if (m_in_burst) begin
          m_ptr = (m_own + 1) % N;
          m_in_burst = 0;
        end
        for (int k = 0; k < N; k++)
          if (w < 0 && req[idx_t'((m_ptr + k) % N)]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          if (lock[idx_t'(w)]) begin
            m_in_burst = 1; m_own = w; m_run = 1;
          end else begin
            m_ptr = (w + 1) % N;
          end
        end
      end
    end
    if (w >= 0) begin
      g = N'(1) << w;
      exp_ram_addr = a_in[idx_t'(w)];
    end
    exp_gnt = g;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    chk({tag, "_ram_addr"}, 64'(ram_addr), 64'(exp_ram_addr));
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(exp_rd_valid));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(exp_rd_data));
    chk({tag, "_onehot"}, 64'({$onehot0(gnt), $onehot0(rd_valid)}), 64'(2'b11));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
    @(negedge clk);
  endtask

  // Entered at a falling edge; leaves at a falling edge with rst released.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_gnt"}, 64'(gnt), 64'(0));
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
    chk({tag, "_ram_addr"}, 64'(ram_addr), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int run0, blen;
    logic [N-1:0] seq [12];

    fib_table[0] = '0;
    fib_table[1] = 16'd1;
    for (int i = 2; i < 1024; i++) fib_table[i] = fib_table[i-1] + fib_table[i-2];

    a_in[0] = 10'd3; a_in[1] = 10'd7; a_in[2] = 10'd5; a_in[3] = 10'd12;

    // Row 0 is the hold-off edge right after reset release.
    vecs[0]  = '{4'b1111, 4'b0000, 10'd0,  4'b0000, 16'd0};
    vecs[1]  = '{4'b1111, 4'b0001, 10'd3,  4'b0000, 16'd0};
    vecs[2]  = '{4'b1111, 4'b0010, 10'd7,  4'b0001, fib_table[3]};
    vecs[3]  = '{4'b1111, 4'b0100, 10'd5,  4'b0010, fib_table[7]};
    vecs[4]  = '{4'b1111, 4'b1000, 10'd12, 4'b0100, fib_table[5]};
    vecs[5]  = '{4'b1111, 4'b0001, 10'd3,  4'b1000, fib_table[12]};
    vecs[6]  = '{4'b0000, 4'b0000, 10'd3,  4'b0001, fib_table[3]};
    vecs[7]  = '{4'b0000, 4'b0000, 10'd3,  4'b0000, fib_table[3]};
    vecs[8]  = '{4'b0100, 4'b0100, 10'd5,  4'b0000, fib_table[3]};
    vecs[9]  = '{4'b0000, 4'b0000, 10'd5,  4'b0100, fib_table[5]};
    vecs[10] = '{4'b0000, 4'b0000, 10'd5,  4'b0000, fib_table[5]};
    vecs[11] = '{4'b1001, 4'b1000, 10'd12, 4'b0000, fib_table[5]};
    vecs[12] = '{4'b0001, 4'b0001, 10'd3,  4'b1000, fib_table[12]};
    vecs[13] = '{4'b0000, 4'b0000, 10'd3,  4'b0001, fib_table[3]};

    @(negedge clk);
    apply_reset("rst0");

    for (int r = 0; r < 14; r++) begin
      req = vecs[r].req;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_gnt", r), 64'(gnt), 64'(vecs[r].gnt));
      chk($sformatf("vec%0d_ram_addr", r), 64'(ram_addr), 64'(vecs[r].ra));
      chk($sformatf("vec%0d_rd_valid", r), 64'(rd_valid), 64'(vecs[r].rv));
      chk($sformatf("vec%0d_rd_data", r), 64'(rd_data), 64'(vecs[r].rd));
      $display("vec %0d req=%b gnt=%b ram_addr=%0d rd_valid=%b rd_data=%0h", r, req, gnt, ram_addr, rd_valid, rd_data);
      @(negedge clk);
    end

    // Locked requester 0 against waiting requester 1.
    apply_reset("rst1");
    req = 4'b0011; lock = 4'b0001;
    tick("burst_arm");
    for (int i = 0; i < 12; i++) begin
      tick($sformatf("burst%0d", i));
      seq[i] = gnt;
    end
    blen = 0;
    for (int i = 0; i < 12; i++) if (blen == i && seq[i] == 4'b0001) blen++;
    chk("burst_len", 64'(blen), 64'(MB));
    chk("burst_next_gnt", 64'(seq[8]), 64'(4'b0010));
    $display("burst len=%0d next=%b", blen, seq[8]);
    req = '0; lock = '0;
    tick("burst_drop");
    req = 4'b1111;
    tick("burst_ptr");
    req = '0;
    tick("burst_tail");

    // Locked requester 0 alone: no rotation, no limit.
    apply_reset("rst2");
    a_in[0] = 10'd9;
    req = 4'b0001; lock = 4'b0001;
    tick("solo_arm");
    run0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick($sformatf("solo%0d", i));
      if (gnt === 4'b0001) run0++;
    end
    chk("solo_grants", 64'(run0), 64'(20));
    $display("solo grants=%0d", run0);

    // Idle after activity: outputs quiet, ram_addr holds.
    req = '0; lock = '0;
    for (int i = 0; i < 10; i++) tick($sformatf("idle%0d", i));
    chk("idle_ram_addr_hold", 64'(ram_addr), 64'(10'd9));
    $display("idle ram_addr=%0d", ram_addr);

    // Reset during a burst with read data in flight.
    req = 4'b1001; lock = 4'b0001;
    tick("rb0");
    tick("rb1");
    tick("rb2");
    apply_reset("rst_burst");
    req = 4'b1000; lock = '0;
    tick("post_arm");
    chk("post_arm_gnt", 64'(gnt), 64'(0));
    tick("post_gnt");
    chk("post_gnt3", 64'(gnt), 64'(4'b1000));
    req = 4'b0011;
    tick("post_ptr");
    chk("post_ptr_gnt0", 64'(gnt), 64'(4'b0001));
    $display("post-reset gnt=%b", gnt);

    // Random traffic from requesters that hold until granted.
    apply_reset("rst3");
    req = '0; lock = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[idx_t'(i)] || exp_gnt[idx_t'(i)]) begin
          req[idx_t'(i)]  = ($urandom_range(0, 2) != 0);
          lock[idx_t'(i)] = ($urandom_range(0, 3) == 0);
          a_in[idx_t'(i)] = AW'($urandom_range(0, 1023));
        end
      end
      tick($sformatf("rnd%0d", c));
      $display("rnd %0d req=%b lock=%b gnt=%b ram_addr=%0d rd_valid=%b rd_data=%0h", c, req, lock, gnt, ram_addr, rd_valid, rd_data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fib_ram_arbiter.md
FIB_RAM_ARBITER -- requirements
Module: fib_ram_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the Fibonacci table port.
REQ-002 Parameter ADDR_W, default 10: table address width (cnt_a width).
REQ-003 Parameter DATA_W, default 16: table data width (mema width).
REQ-004 Parameter MAX_BURST, default 8: maximum consecutive grants to one locked requester while others wait.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 req  in  N_REQ  per-requester read request, level.
REQ-008 lock  in  N_REQ  per-requester burst hold request, meaningful only with req.
REQ-009 addr  in  N_REQ*ADDR_W  per-requester table address; requester i in slice [i*ADDR_W +: ADDR_W].
REQ-010 gnt  out  N_REQ  one-hot or zero; high one cycle per accepted request.
REQ-011 ram_addr  out  ADDR_W  drives cnt_a of the shared table.
REQ-012 ram_data  in  DATA_W  table read data (mema), combinational from ram_addr.
REQ-013 rd_valid  out  N_REQ  one-hot or zero; marks rd_data owner.
REQ-014 rd_data  out  DATA_W  registered table data.

Function
REQ-015 At most one gnt bit and at most one rd_valid bit SHALL be high in any cycle.
REQ-016 Arbitration SHALL be evaluated every cycle on sampled req; winner registered into gnt and ram_addr at the same edge (gnt, ram_addr valid cycle t+1 for req at cycle t).
REQ-017 rd_data SHALL capture ram_data and rd_valid SHALL equal the previous cycle's gnt, giving req-to-data latency of 2 cycles.
REQ-018 Requester SHALL hold req and addr stable until it sees gnt; a grant consumes exactly one request; continued req yields further arbitration.
REQ-019 Round-robin: search starts at ptr, ascending, wrapping N_REQ-1 to 0; after a normal grant to i, ptr becomes (i+1) mod N_REQ.
REQ-020 FSM states IDLE (no grant pending), SERVE (single grants), BURST (locked owner).
REQ-021 IDLE->SERVE on any req; SERVE->IDLE when no req; SERVE->BURST when winner has lock high; BURST->SERVE when owner drops req or lock, or burst_cnt reaches MAX_BURST while any other req is high.
REQ-022 In BURST, owner SHALL be granted every cycle its req is high; ptr unchanged until exit, then ptr = owner+1.
REQ-023 burst_cnt SHALL count grants in BURST, clear on entry/exit, saturate at MAX_BURST; with no competing req, burst continues past MAX_BURST without rotation.
REQ-024 Requester dropping req without grant SHALL not be granted; no grant when req is all zero, ram_addr holds last value.
REQ-025 Simultaneous requests from all N_REQ SHALL each be granted within N_REQ cycles absent lock, within N_REQ*MAX_BURST with lock.

Reset
REQ-026 On rst low, immediately: gnt=0, rd_valid=0, rd_data=0, ram_addr=0, ptr=0, burst_cnt=0, state=IDLE.
REQ-027 Reset mid-operation SHALL discard in-flight grant and data; first grant after release no earlier than second rising edge after rst rises.

Structure
REQ-028 State encoding, ADDR_W/DATA_W defaults and MAX_BURST default SHALL live in shared package fib_pkg.
REQ-029 Round-robin priority selection (req, ptr -> one-hot winner) SHALL be one sub-module rr_pick; FSM, counters, and data register in fib_ram_arbiter.
REQ-030 Arbiter SHALL instantiate no table; top level connects ram_addr->cnt_a, mema->ram_data.

Verification
REQ-031 Single requester: req[2]=1, addr2=5 for 1 cycle held until gnt -> gnt[2] at t+1, ram_addr=5, rd_valid[2] with rd_data=table[5] at t+2.
REQ-032 All req=4'b1111, no lock, ptr=0 -> grants 0,1,2,3,0 in consecutive cycles; each rd_data matches own address one cycle later.
REQ-033 req0 with lock, req1 high, MAX_BURST=8 -> gnt[0] 8 cycles, then gnt[1]; ptr=1 afterward.
REQ-034 req0 with lock alone for 20 cycles -> gnt[0] all 20 cycles, no rotation.
REQ-035 rst asserted during BURST with rd_valid pending -> all outputs 0 same cycle; after release, req3 alone granted, ptr restarts at 0.
REQ-036 req all zero for 10 cycles after activity -> gnt=0, rd_valid=0, ram_addr holds last value, state IDLE.
